// File: rtl/cpu86_retire_checker.sv
// cpu86_retire_checker: compares the DUT register-retire stream against
// buffered golden snapshots, resyncs after golden jumps and tracks errors.
module cpu86_retire_checker #(
  parameter int REG_N        = 11,
  parameter int REG_W        = 16,
  parameter int OP_W         = 5,
  parameter int DEPTH        = 16,
  parameter int MAX_ERRORS   = 100,
  parameter int SYNC_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dut_valid,
  input  logic [OP_W-1:0]        dut_op,
  input  logic [REG_N*REG_W-1:0] dut_regs,
  input  logic                   gold_valid,
  output logic                   gold_ready,
  input  logic [REG_N*REG_W-1:0] gold_regs,
  input  logic [REG_N-1:0]       gold_mask,
  input  logic                   gold_jumped,
  input  logic [REG_W-1:0]       gold_new_cs,
  input  logic [REG_W-1:0]       gold_new_ip,
  output logic                   mismatch,
  output logic [REG_N-1:0]       mismatch_vec,
  output logic [OP_W-1:0]        mismatch_op,
  output logic                   underflow,
  output logic                   skip,
  output logic                   in_sync,
  output logic                   halted,
  output logic [CNT_W-1:0]       error_cnt,
  output logic [CNT_W-1:0]       checked_cnt,
  output logic [CNT_W-1:0]       skipped_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]       FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  MAX_E    = CNT_W'(MAX_ERRORS);
  localparam logic [31:0]       TOUT_LIM = 32'(SYNC_TIMEOUT);

  typedef enum logic [1:0] {ST_RUN, ST_SYNC, ST_HALT} state_t;

  state_t state, state_nx;

  logic [REG_N*REG_W-1:0] f_regs [DEPTH];
  logic [REG_N-1:0]       f_mask [DEPTH];
  logic                   f_jmp  [DEPTH];
  logic [REG_W-1:0]       f_cs   [DEPTH];
  logic [REG_W-1:0]       f_ip   [DEPTH];
  logic [AW-1:0]          rd_ptr, wr_ptr;
  logic [AW:0]            count;

  logic                   push, pop, empty;
  logic [REG_N-1:0]       cmp_vec;
  logic                   do_under, do_mis, do_skip, do_tout;
  logic [31:0]            tout, tout_nx;
  logic [REG_W-1:0]       tgt_cs, tgt_ip, tgt_cs_nx, tgt_ip_nx;
  logic [CNT_W-1:0]       err_nx;
  logic                   retire, tgt_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  assign empty      = (count == '0);
  assign gold_ready = (count < FULL_CNT) && (state != ST_HALT);
  assign push       = gold_valid && gold_ready;
  assign in_sync    = (state == ST_RUN);
  assign halted     = (state == ST_HALT);
  assign tgt_hit    = (dut_regs[0 +: REG_W] == tgt_cs) && (dut_regs[REG_W +: REG_W] == tgt_ip);

  // Per-register compare of the DUT snapshot against the FIFO head under its mask.
  always_comb begin
    cmp_vec = '0;
    for (int unsigned i = 0; i < REG_N; i++)
      cmp_vec[i] = f_mask[rd_ptr][i] &&
                   (dut_regs[i*REG_W +: REG_W] != f_regs[rd_ptr][i*REG_W +: REG_W]);
  end

  // Next-state and per-retire event decode.
  always_comb begin
    state_nx  = state;
    retire    = 1'b0;
    pop       = 1'b0;
    do_under  = 1'b0;
    do_mis    = 1'b0;
    do_skip   = 1'b0;
    do_tout   = 1'b0;
    tout_nx   = tout;
    tgt_cs_nx = tgt_cs;
    tgt_ip_nx = tgt_ip;
    unique case (state)
      ST_RUN:  retire = dut_valid;
      ST_SYNC: begin
        if (dut_valid) begin
          if (tgt_hit) begin
            retire   = 1'b1;
            state_nx = ST_RUN;
          end else begin
            do_skip = 1'b1;
            tout_nx = tout + 32'd1;
            if (tout + 32'd1 >= TOUT_LIM) begin
              do_tout  = 1'b1;
              state_nx = ST_HALT;
            end
          end
        end
      end
      default: ;
    endcase
    if (retire) begin
      if (empty) begin
        do_under = 1'b1;
      end else begin
        pop    = 1'b1;
        do_mis = |cmp_vec;
        if (f_jmp[rd_ptr]) begin
          tgt_cs_nx = f_cs[rd_ptr];
          tgt_ip_nx = f_ip[rd_ptr];
          tout_nx   = '0;
          state_nx  = ST_SYNC;
        end
      end
    end
    // Halt decision uses the post-update, saturated error count.
    err_nx = sat_inc(error_cnt, do_under || do_mis || do_tout);
    if (state != ST_HALT && err_nx > MAX_E)
      state_nx = ST_HALT;
  end

  // Golden FIFO storage; contents need no reset since pointers gate validity.
  always_ff @(posedge clk) begin
    if (push) begin
      f_regs[wr_ptr] <= gold_regs;
      f_mask[wr_ptr] <= gold_mask | REG_N'(3);
      f_jmp[wr_ptr]  <= gold_jumped;
      f_cs[wr_ptr]   <= gold_new_cs;
      f_ip[wr_ptr]   <= gold_new_ip;
    end
  end

  // State, FIFO pointers, counters and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_RUN;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      tout         <= '0;
      tgt_cs       <= '0;
      tgt_ip       <= '0;
      mismatch     <= 1'b0;
      mismatch_vec <= '0;
      mismatch_op  <= '0;
      underflow    <= 1'b0;
      skip         <= 1'b0;
      error_cnt    <= '0;
      checked_cnt  <= '0;
      skipped_cnt  <= '0;
    end else begin
      state     <= state_nx;
      tout      <= tout_nx;
      tgt_cs    <= tgt_cs_nx;
      tgt_ip    <= tgt_ip_nx;
      mismatch  <= do_mis;
      underflow <= do_under;
      skip      <= do_skip;
      error_cnt <= err_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        mismatch_vec <= cmp_vec;
        mismatch_op  <= dut_op;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      checked_cnt <= sat_inc(checked_cnt, pop);
      skipped_cnt <= sat_inc(skipped_cnt, do_skip);
    end
  end

endmodule

// File: tb/tb_cpu86_retire_checker.sv
// Directed, table-driven bench for cpu86_retire_checker.
module tb_cpu86_retire_checker;

  localparam int REG_N = 11;
  localparam int REG_W = 16;
  localparam int OP_W  = 5;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  typedef logic [REG_N*REG_W-1:0] snap_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              dut_valid;
  logic [OP_W-1:0]   dut_op;
  snap_t             dut_regs;
  logic              gold_valid;
  logic              gold_ready;
  snap_t             gold_regs;
  logic [REG_N-1:0]  gold_mask;
  logic              gold_jumped;
  logic [REG_W-1:0]  gold_new_cs, gold_new_ip;
  logic              mismatch;
  logic [REG_N-1:0]  mismatch_vec;
  logic [OP_W-1:0]   mismatch_op;
  logic              underflow, skip, in_sync, halted;
  logic [CNT_W-1:0]  error_cnt, checked_cnt, skipped_cnt;

  int checks = 0;
  int errors = 0;

  cpu86_retire_checker #(
    .REG_N(REG_N), .REG_W(REG_W), .OP_W(OP_W), .DEPTH(DEPTH),
    .MAX_ERRORS(2), .SYNC_TIMEOUT(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .dut_valid(dut_valid), .dut_op(dut_op), .dut_regs(dut_regs),
    .gold_valid(gold_valid), .gold_ready(gold_ready), .gold_regs(gold_regs),
    .gold_mask(gold_mask), .gold_jumped(gold_jumped),
    .gold_new_cs(gold_new_cs), .gold_new_ip(gold_new_ip),
    .mismatch(mismatch), .mismatch_vec(mismatch_vec), .mismatch_op(mismatch_op),
    .underflow(underflow), .skip(skip), .in_sync(in_sync), .halted(halted),
    .error_cnt(error_cnt), .checked_cnt(checked_cnt), .skipped_cnt(skipped_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [REG_N-1:0] mask;
    int               dreg;
    logic [REG_W-1:0] delta;
    logic             exp_mis;
    logic [REG_N-1:0] exp_vec;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic snap_t mk(input logic [REG_W-1:0] cs, input logic [REG_W-1:0] ip);
    snap_t s;
    for (int i = 0; i < REG_N; i++) s[i*REG_W +: REG_W] = REG_W'(16'h1000 + i);
    s[0 +: REG_W]       = cs;
    s[REG_W +: REG_W]   = ip;
    s[2*REG_W +: REG_W] = 16'h1234;
    return s;
  endfunction

  task automatic do_reset();
    reset = 1'b1; dut_valid = 1'b0; dut_op = '0; dut_regs = '0;
    gold_valid = 1'b0; gold_regs = '0; gold_mask = '0; gold_jumped = 1'b0;
    gold_new_cs = '0; gold_new_ip = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input snap_t r, input logic [REG_N-1:0] m, input logic j,
                      input logic [REG_W-1:0] cs, input logic [REG_W-1:0] ip);
    gold_valid = 1'b1; gold_regs = r; gold_mask = m; gold_jumped = j;
    gold_new_cs = cs; gold_new_ip = ip;
    tick();
    gold_valid = 1'b0; gold_jumped = 1'b0;
  endtask

  task automatic retire(input snap_t r, input logic [OP_W-1:0] op);
    dut_valid = 1'b1; dut_regs = r; dut_op = op;
    tick();
    dut_valid = 1'b0;
  endtask

  initial begin
    snap_t s;
    tbl[0] = '{11'h7FF, 2,  16'h0000, 1'b0, 11'h000};
    tbl[1] = '{11'h7FB, 2,  16'h0001, 1'b0, 11'h000};
    tbl[2] = '{11'h7FF, 2,  16'h0001, 1'b1, 11'h004};
    tbl[3] = '{11'h000, 0,  16'h0100, 1'b1, 11'h001};
    tbl[4] = '{11'h000, 1,  16'h0002, 1'b1, 11'h002};
    tbl[5] = '{11'h7FF, 10, 16'h8000, 1'b1, 11'h400};
    tbl[6] = '{11'h020, 9,  16'hFFFF, 1'b0, 11'h000};

    // Reset values
    do_reset();
    chk("rst_ready", 32'(gold_ready), 32'd1);
    chk("rst_mismatch", 32'(mismatch), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_skip", 32'(skip), 32'd0);
    chk("rst_vec", 32'(mismatch_vec), 32'd0);
    chk("rst_op", 32'(mismatch_op), 32'd0);
    chk("rst_in_sync", 32'(in_sync), 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_err", 32'(error_cnt), 32'd0);
    chk("rst_chk", 32'(checked_cnt), 32'd0);
    chk("rst_skp", 32'(skipped_cnt), 32'd0);

    // Masked single-compare table
    for (int t = 0; t < 7; t++) begin
      do_reset();
      s = mk(16'h0000, 16'h0040);
      push(s, tbl[t].mask, 1'b0, '0, '0);
      s[tbl[t].dreg*REG_W +: REG_W] = s[tbl[t].dreg*REG_W +: REG_W] ^ tbl[t].delta;
      retire(s, OP_W'(t + 3));
      chk($sformatf("tbl%0d_mis", t), 32'(mismatch), 32'(tbl[t].exp_mis));
      chk($sformatf("tbl%0d_vec", t), 32'(mismatch_vec), 32'(tbl[t].exp_vec));
      chk($sformatf("tbl%0d_op", t), 32'(mismatch_op), 32'(t + 3));
      chk($sformatf("tbl%0d_err", t), 32'(error_cnt), 32'(tbl[t].exp_mis));
      chk($sformatf("tbl%0d_chk", t), 32'(checked_cnt), 32'd1);
      tick();
      chk($sformatf("tbl%0d_pulse_end", t), 32'(mismatch), 32'd0);
      chk($sformatf("tbl%0d_vec_hold", t), 32'(mismatch_vec), 32'(tbl[t].exp_vec));
    end

    // Match stream filling the FIFO, then back-to-back retires
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(mk(16'h0000, 16'(i * 2)), '1, 1'b0, '0, '0);
    chk("full_ready", 32'(gold_ready), 32'd0);
    dut_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      dut_regs = mk(16'h0000, 16'(i * 2));
      tick();
      chk($sformatf("stream%0d_mis", i), 32'(mismatch), 32'd0);
      if (i == 0) chk("ready_after_pop", 32'(gold_ready), 32'd1);
    end
    dut_valid = 1'b0;
    chk("stream_chk", 32'(checked_cnt), 32'(DEPTH));
    chk("stream_err", 32'(error_cnt), 32'd0);
    retire(mk(16'h0000, 16'h0000), '0);
    chk("empty_underflow", 32'(underflow), 32'd1);
    chk("empty_err", 32'(error_cnt), 32'd1);
    tick();
    chk("underflow_end", 32'(underflow), 32'd0);

    // Push and retire on the same cycle with an empty FIFO: no bypass
    do_reset();
    gold_valid = 1'b1; gold_regs = mk(16'h0000, 16'h0050); gold_mask = '1;
    dut_valid = 1'b1; dut_regs = mk(16'h0000, 16'h0050);
    tick();
    gold_valid = 1'b0; dut_valid = 1'b0;
    chk("nobypass_uf", 32'(underflow), 32'd1);
    chk("nobypass_chk", 32'(checked_cnt), 32'd0);
    retire(mk(16'h0000, 16'h0050), '0);
    chk("nobypass_pop_mis", 32'(mismatch), 32'd0);
    chk("nobypass_pop_chk", 32'(checked_cnt), 32'd1);

    // Jump resync
    do_reset();
    push(mk(16'h0000, 16'h000E), '1, 1'b1, 16'hF000, 16'h0100);
    push(mk(16'hF000, 16'h0100), '1, 1'b0, '0, '0);
    retire(mk(16'h0000, 16'h000E), '0);
    chk("jmp_head_mis", 32'(mismatch), 32'd0);
    chk("jmp_in_sync", 32'(in_sync), 32'd0);
    retire(mk(16'h0000, 16'h0010), '0);
    chk("wp1_skip", 32'(skip), 32'd1);
    chk("wp1_in_sync", 32'(in_sync), 32'd0);
    retire(mk(16'h0000, 16'h0012), '0);
    chk("wp2_skip", 32'(skip), 32'd1);
    chk("wp2_skipped", 32'(skipped_cnt), 32'd2);
    retire(mk(16'hF000, 16'h0100), '0);
    chk("tgt_skip", 32'(skip), 32'd0);
    chk("tgt_mis", 32'(mismatch), 32'd0);
    chk("tgt_chk", 32'(checked_cnt), 32'd2);
    chk("tgt_in_sync", 32'(in_sync), 32'd1);
    chk("tgt_err", 32'(error_cnt), 32'd0);

    // Resync timeout
    do_reset();
    push(mk(16'h0000, 16'h000E), '1, 1'b1, 16'hF000, 16'h0100);
    retire(mk(16'h0000, 16'h000E), '0);
    for (int i = 0; i < 4; i++) begin
      retire(mk(16'h0000, 16'(16'h0020 + i)), '0);
      chk($sformatf("to%0d_skip", i), 32'(skip), 32'd1);
      chk($sformatf("to%0d_halted", i), 32'(halted), 32'(i == 3));
    end
    chk("to_err", 32'(error_cnt), 32'd1);
    chk("to_ready", 32'(gold_ready), 32'd0);
    gold_valid = 1'b1; gold_regs = mk(16'hF000, 16'h0100); gold_mask = '1;
    retire(mk(16'hF000, 16'h0100), '0);
    retire(mk(16'h0000, 16'h0030), '0);
    gold_valid = 1'b0;
    chk("halt_skipped", 32'(skipped_cnt), 32'd4);
    chk("halt_err", 32'(error_cnt), 32'd1);
    chk("halt_chk", 32'(checked_cnt), 32'd1);
    chk("halt_skip", 32'(skip), 32'd0);
    chk("halt_sticky", 32'(halted), 32'd1);

    // Error budget exceeded, then reset
    do_reset();
    for (int i = 0; i < 3; i++) push(mk(16'h0000, 16'h0060), '1, 1'b0, '0, '0);
    s = mk(16'h0000, 16'h0060);
    s[3*REG_W +: REG_W] = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      retire(s, '0);
      chk($sformatf("bud%0d_mis", i), 32'(mismatch), 32'd1);
      chk($sformatf("bud%0d_err", i), 32'(error_cnt), 32'(i + 1));
      chk($sformatf("bud%0d_halted", i), 32'(halted), 32'(i == 2));
    end
    do_reset();
    chk("post_rst_err", 32'(error_cnt), 32'd0);
    chk("post_rst_chk", 32'(checked_cnt), 32'd0);
    chk("post_rst_halted", 32'(halted), 32'd0);
    chk("post_rst_ready", 32'(gold_ready), 32'd1);
    chk("post_rst_in_sync", 32'(in_sync), 32'd1);
    retire(mk(16'h0000, 16'h0060), '0);
    chk("post_rst_flushed", 32'(underflow), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
